// File: rtl/ours_ppln_rr_arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin pipeline arbiter.
package ours_ppln_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Requester id width; a single requester still gets a 1-bit id.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ours_ppln_rr_arb_if.sv
// Requester-side and downstream-side channel bundle of the round-robin arbiter.
interface ours_ppln_rr_arb_if
    import ours_ppln_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = id_width(N);

    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_last;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic [IDW-1:0]     out_id;
    logic               locked;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, out_id, locked
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, out_id, locked
    );

endinterface

// File: rtl/ours_ppln_rr_arb_pick.sv
// Rotate-priority picker: first asserted request scanning from ptr upward with wrap.
module ours_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           any_o,
    output logic [IDW-1:0] idx_o
);

    // Walk offsets from the far end so the lowest offset from ptr wins last.
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                idx_o = IDW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/ours_ppln_rr_arb.sv
// N-to-1 round-robin arbiter with packet lock and a registered output stage.
module ours_ppln_rr_arb
    import ours_ppln_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int LOCK_LAST = 1
) (
    input  logic               clk,
    input  logic               rst,
    ours_ppln_rr_arb_if.slave  bus
);

    localparam int IDW = id_width(N);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   lock_id_q, lock_id_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic [IDW-1:0]   out_id_q;

    logic             pick_any;
    logic [IDW-1:0]   pick_idx;
    logic [IDW-1:0]   g;
    logic             can_acc;
    logic [N-1:0]     ready;
    logic             in_beat;
    logic             g_last;

    ours_rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign g       = (state_q == ARB_LOCKED) ? lock_id_q : pick_idx;
    assign can_acc = !out_valid_q || bus.out_ready;
    assign g_last  = bus.req_last[g];

    // Ready is gated by rst so nothing is offered while the block is held in reset.
    always_comb begin
        ready = '0;
        if (!rst && can_acc && ((state_q == ARB_LOCKED) || pick_any)) begin
            ready[g] = 1'b1;
        end
    end

    assign in_beat = |(bus.req_valid & ready);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_id_d = lock_id_q;
        if (in_beat) begin
            if (LOCK_LAST != 0 && !g_last) begin
                state_d   = ARB_LOCKED;
                lock_id_d = g;
            end else begin
                state_d = ARB_IDLE;
                ptr_d   = (g == IDW'(N - 1)) ? '0 : g + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else if (in_beat) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.req_data[int'(g) * WIDTH +: WIDTH];
            out_last_q  <= g_last;
            out_id_q    <= g;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_id    = out_id_q;
    assign bus.locked    = (state_q == ARB_LOCKED);

`ifndef SYNTHESIS
    if (N < 1) begin : g_bad_n
        $error("ours_ppln_rr_arb: N must be at least 1");
    end

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.req_ready));

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_last) && $stable(bus.out_id)));

    // lock_id_q cannot change while locked without an in-beat, so no $past is needed.
    a_locked_valid_hold: assert property (@(posedge clk) disable iff (rst)
        ((state_q == ARB_LOCKED) && bus.req_valid[lock_id_q] && !bus.req_ready[lock_id_q]) |=>
        bus.req_valid[lock_id_q]);
`endif

endmodule

// File: tb/tb_ours_ppln_rr_arb.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural arbiter model.
module tb_ours_ppln_rr_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ours_ppln_rr_arb_if #(.N(N), .WIDTH(W)) bus ();

    ours_ppln_rr_arb #(.N(N), .WIDTH(W), .LOCK_LAST(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the channel and what the output stage holds.
    int         m_ptr;
    int         m_owner;
    bit         m_locked;
    bit         m_ov;
    logic [7:0] m_od;
    bit         m_ol;
    int         m_oid;
    bit         last_inb;
    int         last_g;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ptr = 0; m_owner = 0; m_locked = 0;
        m_ov = 0; m_od = '0; m_ol = 0; m_oid = 0;
        last_inb = 0; last_g = -1;
    endfunction

    // Grant by the arbitration rules: locked owner, else first valid scanning from ptr.
    function automatic void model_pick(output int g, output logic [N-1:0] er);
        int cand;
        bit can;
        cand = -1;
        can  = !m_ov || bus.out_ready;
        if (m_locked) cand = m_owner;
        else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (cand < 0 && bus.req_valid[j]) cand = j;
            end
        end
        er = '0;
        g  = cand;
        if (can && cand >= 0) er[cand] = 1'b1;
    endfunction

    // Entered at posedge+1 with inputs applied; checks at the falling edge, returns at next posedge+1.
    task automatic step();
        int g;
        logic [N-1:0] er;
        bit inb;
        #4;
        model_pick(g, er);
        check_eq("req_ready", bus.req_ready, er);
        check_eq("out_valid", bus.out_valid, m_ov);
        check_eq("locked", bus.locked, m_locked);
        if (m_ov) begin
            check_eq("out_data", bus.out_data, m_od);
            check_eq("out_last", bus.out_last, m_ol);
            check_eq("out_id", bus.out_id, m_oid);
        end
        inb = (g >= 0) && er[g] && bus.req_valid[g];
        if (inb) begin
            m_ov  = 1;
            m_od  = bus.req_data[g*W +: W];
            m_ol  = bus.req_last[g];
            m_oid = g;
            if (bus.req_last[g]) begin
                m_locked = 0;
                m_ptr    = (g + 1) % N;
            end else begin
                m_locked = 1;
                m_owner  = g;
            end
        end else if (m_ov && bus.out_ready) begin
            m_ov = 0;
        end
        last_inb = inb;
        last_g   = g;
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [7:0] d, input logic l);
        bus.req_valid[i]       = 1'b1;
        bus.req_data[i*W +: W] = d;
        bus.req_last[i]        = l;
    endtask

    int rem[N];
    bit pend[N];

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.req_valid = '1;
        bus.req_last  = '1;
        bus.req_data  = 32'h33221100;
        model_reset();

        // Reset with every requester asking.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_locked", bus.locked, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        check_eq("rst_out_id", bus.out_id, 0);
        rst = 1'b0;
        step();
        check_eq("first_id", bus.out_id, 0);

        // Fairness with single-beat packets at full rate.
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq("rr_id", bus.out_id, k % N);
            check_eq("rr_valid", bus.out_valid, 1);
        end
        bus.req_valid = '0;
        step();

        // Three-beat packet from req1 while req2 waits.
        set_beat(1, 8'hA1, 1'b0);
        set_beat(2, 8'hB2, 1'b1);
        step();
        check_eq("pkt_id1", bus.out_id, 1);
        check_eq("pkt_d1", bus.out_data, 8'hA1);
        check_eq("pkt_r2_blk1", bus.req_ready[2], 0);
        set_beat(1, 8'hA2, 1'b0);
        step();
        check_eq("pkt_d2", bus.out_data, 8'hA2);
        check_eq("pkt_lock", bus.locked, 1);
        check_eq("pkt_r2_blk2", bus.req_ready[2], 0);
        set_beat(1, 8'hA3, 1'b1);
        step();
        check_eq("pkt_d3", bus.out_data, 8'hA3);
        check_eq("pkt_last", bus.out_last, 1);
        bus.req_valid[1] = 1'b0;
        step();
        check_eq("pkt_next_id", bus.out_id, 2);
        check_eq("pkt_next_d", bus.out_data, 8'hB2);
        bus.req_valid = '0;
        step();

        // Backpressure hold, then release.
        set_beat(3, 8'h3C, 1'b1);
        step();
        bus.out_ready = 1'b0;
        set_beat(3, 8'h3D, 1'b1);
        set_beat(0, 8'h0D, 1'b1);
        repeat (5) begin
            step();
            check_eq("bp_data", bus.out_data, 8'h3C);
            check_eq("bp_valid", bus.out_valid, 1);
            check_eq("bp_ready", bus.req_ready, 0);
        end
        bus.out_ready = 1'b1;
        step();
        check_eq("bp_rel_d0", bus.out_data, 8'h0D);
        bus.req_valid[0] = 1'b0;
        step();
        check_eq("bp_rel_d3", bus.out_data, 8'h3D);
        bus.req_valid = '0;
        repeat (2) step();

        // Locked requester drops valid mid-packet while req3 waits.
        set_beat(0, 8'h51, 1'b0);
        set_beat(3, 8'h7E, 1'b1);
        step();
        check_eq("bub_d1", bus.out_data, 8'h51);
        bus.req_valid[0] = 1'b0;
        repeat (2) begin
            step();
            check_eq("bub_locked", bus.locked, 1);
            check_eq("bub_r3_blk", bus.req_ready[3], 0);
            check_eq("bub_out_valid", bus.out_valid, 0);
        end
        set_beat(0, 8'h52, 1'b1);
        step();
        check_eq("bub_d2", bus.out_data, 8'h52);
        check_eq("bub_unlock", bus.locked, 0);
        bus.req_valid[0] = 1'b0;
        step();
        check_eq("bub_r3_id", bus.out_id, 3);
        bus.req_valid = '0;
        step();

        // Async reset while locked, with ptr moved away from 0 first.
        set_beat(1, 8'h61, 1'b1);
        step();
        bus.req_valid = '0;
        set_beat(2, 8'h62, 1'b0);
        step();
        check_eq("ar_locked_pre", bus.locked, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_out_valid", bus.out_valid, 0);
        check_eq("ar_locked", bus.locked, 0);
        check_eq("ar_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        bus.req_valid = '1;
        bus.req_last  = '1;
        step();
        check_eq("ar_first_id", bus.out_id, 0);
        bus.req_valid = '0;
        repeat (2) step();

        // Randomized traffic; a pending beat is held until the model says it was taken.
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            pend[i] = 0;
        end
        repeat (3000) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (last_inb && last_g == i) pend[i] = 0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
                        set_beat(i, 8'($urandom), rem[i] == 1);
                        rem[i]--;
                        pend[i] = 1;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
